// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and config-word field positions for the LED sequencer
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_DIM    = 2'b11
  } led_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } led_state_e;

  localparam int CFG_PAT_LSB  = 0;
  localparam int CFG_MODE_LSB = 4;
  localparam int CFG_PER_LSB  = 8;
  localparam int CFG_DUTY_LSB = 16;
  localparam int CFG_EN_BIT   = 31;

  // A zero step period would never fire; treat it as one tick.
  function automatic logic [7:0] eff_period(input logic [7:0] per);
    return (per == 8'd0) ? 8'd1 : per;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV enabled clocks
module led_tick_gen #(
  parameter int TICK_DIV = 100800
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - four-LED static/blink/chase/dim sequencer driven by one host config word
// Build option LED_SEQUENCER_GAMMA_EN squares the dim duty when a new word is loaded.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 100800,
  parameter int N_LED    = 4
) (
  input  logic             okClk,
  input  logic             rst_n,
  input  logic [31:0]      cfg,
  output logic [N_LED-1:0] led,
  output logic [N_LED-1:0] led_on,
  output logic             busy
);

  logic [31:0]      cfg_q;
  led_state_e       state_q, state_d;
  led_mode_e        mode_q, mode_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic [N_LED-1:0] shift_q, shift_d;
  logic [N_LED-1:0] led_on_q, led_on_d;
  logic [7:0]       per_q, per_d;
  logic [7:0]       duty_q, duty_d;
  logic [7:0]       step_cnt_q, step_cnt_d;
  logic [7:0]       pwm_q;
  logic             phase_q, phase_d;
  logic             chg, tick, step, run, load;
  logic [7:0]       duty_load;

  assign chg  = (cfg != cfg_q);
  assign run  = (state_q == ST_RUN);
  assign load = (state_q == ST_LOAD);
  assign step = tick && (step_cnt_q == per_q - 8'd1);

`ifdef LED_SEQUENCER_GAMMA_EN
  logic [15:0] duty_sq;
  assign duty_sq   = {8'd0, cfg_q[CFG_DUTY_LSB +: 8]} * {8'd0, cfg_q[CFG_DUTY_LSB +: 8]};
  assign duty_load = duty_sq[15:8];
`else
  assign duty_load = cfg_q[CFG_DUTY_LSB +: 8];
`endif

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (okClk),
    .rst_ni (rst_n),
    .clr_i  (load),
    .en_i   (run),
    .tick_o (tick)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    pat_d      = pat_q;
    per_d      = per_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    phase_d    = phase_q;
    shift_d    = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (chg && cfg[CFG_EN_BIT]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        mode_d     = led_mode_e'(cfg_q[CFG_MODE_LSB +: 2]);
        pat_d      = cfg_q[CFG_PAT_LSB +: N_LED];
        per_d      = eff_period(cfg_q[CFG_PER_LSB +: 8]);
        duty_d     = duty_load;
        step_cnt_d = '0;
        phase_d    = 1'b0;
        shift_d    = cfg_q[CFG_PAT_LSB +: N_LED];
        // A rewrite landing during LOAD would otherwise be missed once cfg_q catches up.
        if (chg) state_d = cfg[CFG_EN_BIT] ? ST_LOAD : ST_IDLE;
        else     state_d = ST_RUN;
      end
      ST_RUN: begin
        if (chg) begin
          state_d = cfg[CFG_EN_BIT] ? ST_LOAD : ST_IDLE;
        end else if (tick) begin
          step_cnt_d = step ? 8'd0 : step_cnt_q + 8'd1;
          if (step) begin
            phase_d = ~phase_q;
            shift_d = {shift_q[N_LED-2:0], shift_q[N_LED-1]};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output is built from next-state work registers so a new word shows two edges after it lands.
  always_comb begin
    led_on_d = '0;
    if (load || run) begin
      case (mode_d)
        MODE_STATIC: led_on_d = pat_d;
        MODE_BLINK:  led_on_d = phase_d ? '0 : pat_d;
        MODE_CHASE:  led_on_d = shift_d;
        MODE_DIM:    led_on_d = (pwm_q < duty_d) ? pat_d : '0;
        default:     led_on_d = '0;
      endcase
    end
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q      <= '0;
      state_q    <= ST_IDLE;
      mode_q     <= MODE_STATIC;
      pat_q      <= '0;
      per_q      <= 8'd1;
      duty_q     <= '0;
      step_cnt_q <= '0;
      phase_q    <= 1'b0;
      shift_q    <= '0;
      pwm_q      <= '0;
      led_on_q   <= '0;
    end else begin
      cfg_q      <= cfg;
      state_q    <= state_d;
      mode_q     <= mode_d;
      pat_q      <= pat_d;
      per_q      <= per_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      shift_q    <= shift_d;
      pwm_q      <= pwm_q + 8'd1;
      led_on_q   <= led_on_d;
    end
  end

  assign led_on = led_on_q;
  assign busy   = run;

  for (genvar i = 0; i < N_LED; i++) begin : g_od
    assign led[i] = led_on_q[i] ? 1'b0 : 1'bz;
  end

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - directed self-checking bench for led_sequencer with TICK_DIV=4
module tb_led_sequencer;

  logic        okClk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg;
  wire  [3:0]  led_w;
  logic [3:0]  led_on;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int lit;
  int other;

  // Open-drain pins read high when released.
  for (genvar g = 0; g < 4; g++) begin : g_pu
    pullup (led_w[g]);
  end

  led_sequencer #(.TICK_DIV(4), .N_LED(4)) dut (
    .okClk  (okClk),
    .rst_n  (rst_n),
    .cfg    (cfg),
    .led    (led_w),
    .led_on (led_on),
    .busy   (busy)
  );

  always #5 okClk = ~okClk;

`ifdef LED_SEQUENCER_GAMMA_EN
  localparam int DIM64_EXP  = 16;
  localparam int DIM255_EXP = 254;
`else
  localparam int DIM64_EXP  = 64;
  localparam int DIM255_EXP = 255;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge okClk);
    #1;
  endtask

  task automatic count_lit(input int n);
    lit = 0;
    other = 0;
    repeat (n) begin
      if (led_on == 4'hF) lit++;
      else if (led_on != 4'h0) other++;
      cyc(1);
    end
  endtask

  logic [3:0] chase_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_n = 1'b0;
    cfg   = 32'h0;
    cyc(3);
    check("rst_led_on", 32'(led_on), 32'h0);
    check("rst_led", 32'(led_w), 32'hF);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cyc(4);
    check("idle_busy", 32'(busy), 32'h0);

    cfg = 32'h8000_0005;
    cyc(1);
    check("static_load_busy", 32'(busy), 32'h0);
    check("static_load_led_on", 32'(led_on), 32'h0);
    cyc(1);
    check("static_led_on", 32'(led_on), 32'h5);
    check("static_led", 32'(led_w), 32'hA);
    check("static_busy", 32'(busy), 32'h1);

    cfg = 32'h8000_0221;
    cyc(1);
    check("chase_load_hold", 32'(led_on), 32'h5);
    cyc(1);
    check("chase_start", 32'(led_on), 32'h1);
    for (int k = 0; k < 4; k++) begin
      cyc(7);
      check("chase_dwell", 32'(led_on), 32'((k == 0) ? 4'b0001 : chase_seq[k-1]));
      cyc(1);
      check("chase_step", 32'(led_on), 32'(chase_seq[k]));
    end

    cyc(7);
    cfg = 32'h8000_0228;
    cyc(1);
    check("prio_no_rotate", 32'(led_on), 32'h1);
    cyc(1);
    check("prio_new_pattern", 32'(led_on), 32'h8);
    check("prio_busy", 32'(busy), 32'h1);
    cyc(7);
    check("prio_dwell", 32'(led_on), 32'h8);
    cyc(1);
    check("prio_wrap", 32'(led_on), 32'h1);

    cfg = 32'h0;
    cyc(1);
    check("dis_busy", 32'(busy), 32'h0);
    check("dis_hold", 32'(led_on), 32'h1);
    cyc(1);
    check("dis_led_on", 32'(led_on), 32'h0);
    check("dis_led", 32'(led_w), 32'hF);

    cfg = 32'h8000_011F;
    cyc(2);
    check("blink_lit0", 32'(led_on), 32'hF);
    cyc(3);
    check("blink_lit3", 32'(led_on), 32'hF);
    cyc(1);
    check("blink_dark0", 32'(led_on), 32'h0);
    check("blink_dark_led", 32'(led_w), 32'hF);
    cyc(3);
    check("blink_dark3", 32'(led_on), 32'h0);
    cyc(1);
    check("blink_relit", 32'(led_on), 32'hF);
    check("blink_led", 32'(led_w), 32'h0);

    cfg = 32'h8000_001F;
    cyc(2);
    check("per0_lit0", 32'(led_on), 32'hF);
    cyc(3);
    check("per0_lit3", 32'(led_on), 32'hF);
    cyc(1);
    check("per0_dark", 32'(led_on), 32'h0);

    cfg = 32'h8040_003F;
    cyc(2);
    count_lit(256);
    check("dim64_count", 32'(lit), 32'(DIM64_EXP));
    check("dim64_other", 32'(other), 32'h0);

    cfg = 32'h8000_003F;
    cyc(2);
    count_lit(256);
    check("dim0_count", 32'(lit), 32'h0);

    cfg = 32'h80FF_003F;
    cyc(2);
    count_lit(256);
    check("dim255_count", 32'(lit), 32'(DIM255_EXP));

    cfg = 32'h8000_0221;
    cyc(12);
    check("mid_run_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    cfg   = 32'h0;
    #1;
    check("mid_rst_led", 32'(led_w), 32'hF);
    check("mid_rst_led_on", 32'(led_on), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    check("post_rst_idle", 32'(busy), 32'h0);
    check("post_rst_dark", 32'(led_on), 32'h0);
    cfg = 32'h8000_0005;
    cyc(2);
    check("post_rst_static", 32'(led_on), 32'h5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Pattern controller for the four board LEDs; sits between the host wire-in endpoint (32-bit config word) and the open-drain LED pins.
- Sequences static, blink, chase and PWM-dim modes from one config word; re-arms cleanly whenever the host rewrites the word.
- Replaces direct wire-to-LED assignment in the top level.

Parameters:
- TICK_DIV, 100800, okClk cycles per 1 ms tick (okClk = 100.8 MHz).
- N_LED, 4, number of LEDs driven; fixed at 4 for this board.

Ports:
- okClk  input  1  host-interface clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- cfg  input  32  config word from the wire-in endpoint; level-valued, same clock domain.
- led  output  4  open-drain pins: 1'b0 = lit, 1'bz = dark.
- led_on  output  4  active-high lit mask (debug/readback).
- busy  output  1  high in RUN state.

Behaviour:
- cfg fields: [3:0] pattern; [5:4] mode (00 static, 01 blink, 10 chase, 11 dim); [15:8] step period in ticks, 0 treated as 1; [23:16] duty; [31] enable; other bits ignored.
- Reset (async assert, sync-released by caller): FSM=IDLE, cfg_q=0, counters=0, led_on=0, led=all z, busy=0.
- Change detect: cfg_q <= cfg every cycle; chg = (cfg != cfg_q).
- FSM states:
  - IDLE: led_on=0. chg with cfg[31]=1 -> LOAD.
  - LOAD: one cycle; latch fields from cfg_q into work regs; clear prescaler, step counter and phase; shift_reg <= pattern. -> RUN.
  - RUN: chg -> LOAD if cfg[31]=1, else -> IDLE.
- Latency: cfg written at edge N -> LOAD at N+1 -> led_on reflects new config after edge N+2.
- Tick: prescaler counts 0..TICK_DIV-1; tick pulses for one cycle at wrap.
- Step: step counter advances on tick; step pulses when it reaches period-1, then the counter returns to 0.
- Mode outputs:
  - static: led_on = pattern.
  - blink: phase toggles on step; led_on = phase ? 0 : pattern, so lit first.
  - chase: shift_reg rotates left by 1 on step (bit3 -> bit0). Pattern 0 stays dark; pattern 4'hF stays fully lit.
  - dim: pwm_cnt is an 8-bit free-running counter on okClk; led_on = (pwm_cnt < duty) ? pattern : 0. Duty 0 = always dark; duty 255 = dark 1/256.
- led[i] = led_on[i] ? 1'b0 : 1'bz; led_on is registered, so there is no combinational path from cfg.
- Simultaneous events: chg in the same cycle as step -> chg wins; step is discarded.
- Clear enable (cfg[31] 1->0) -> IDLE on the next edge; led_on=0 one cycle later.
- Counter widths: prescaler $clog2(TICK_DIV); step counter 8 bits; all wrap-free by construction.

Optional Feature:
- Macro: LED_SEQUENCER_GAMMA_EN.
- With it: dim mode uses duty_g = (duty*duty)>>8, computed in LOAD into a register. Latency is unchanged; duty 255 -> 254, 16 -> 1.
- Without it: linear duty as above; no multiplier is inferred.

Decomposition:
- Package led_seq_pkg:
  - mode enum (MODE_STATIC, MODE_BLINK, MODE_CHASE, MODE_DIM);
  - FSM state enum (ST_IDLE, ST_LOAD, ST_RUN);
  - cfg field bit-position constants.
- Sub-module led_tick_gen: the prescaler, parameterized by TICK_DIV, outputs the 1-cycle tick.
- Everything else stays in led_sequencer.

Test Plan (bench TICK_DIV=4):
- Reset mid-RUN: assert rst_n=0 while chasing -> led all z, busy=0 immediately; after release, stays IDLE until cfg changes.
- Static: cfg=32'h8000_0005 -> led_on=4'b0101 two cycles after write; led=4'bz0z0.
- Chase: cfg=32'h8000_0221 (period 2, pattern 0001) -> led_on steps 0001, 0010, 0100, 1000, 0001, one step every 8 cycles.
- Blink: cfg=32'h8000_011F (period 1) -> led_on alternates 1111 / 0000 every 4 cycles, starting lit.
- Dim: cfg=32'h8040_003F (duty 64, pattern F) -> led_on=F exactly 64 of 256 cycles; with GAMMA_EN, 16 of 256.
- Disable and change priority: rewrite cfg on the same cycle as a step -> no rotation, LOAD restarts from the new pattern; then cfg=0 -> IDLE, led all z after 2 cycles.
